// File: rtl/axis_dram_fifo_arbiter.sv
// Packet-boundary round-robin arbiter feeding one shared 64-bit CVITA stream FIFO.
// A granted port owns the output until its tlast beat is accepted, so packets never
// interleave. New grants wait for the FIFO's calibration to complete.
//
// Ports:
//   bus_clk, bus_rst_n        single clock, asynchronous active-low reset
//   calib_complete            FIFO ready for use (tie 1 for SRAM FIFO)
//   i_tdata/i_tlast/i_tvalid  NUM_PORTS input streams, port p at [p*WIDTH +: WIDTH]
//   i_tready                  per-port ready, at most one bit high (combinational)
//   o_tdata/o_tlast/o_tvalid  registered output stream towards the FIFO
//   o_tready                  FIFO ready
//   active_port               current or last granted port
//   busy                      high while a packet is being passed
//   pkt_count                 packets delivered to the FIFO, wrapping counter
module axis_dram_fifo_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WIDTH     = 64
) (
  input  logic                           bus_clk,
  input  logic                           bus_rst_n,
  input  logic                           calib_complete,
  input  logic [NUM_PORTS*WIDTH-1:0]     i_tdata,
  input  logic [NUM_PORTS-1:0]           i_tlast,
  input  logic [NUM_PORTS-1:0]           i_tvalid,
  output logic [NUM_PORTS-1:0]           i_tready,
  output logic [WIDTH-1:0]               o_tdata,
  output logic                           o_tlast,
  output logic                           o_tvalid,
  input  logic                           o_tready,
  output logic [$clog2(NUM_PORTS)-1:0]   active_port,
  output logic                           busy,
  output logic [31:0]                    pkt_count
);

  localparam int unsigned PW = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   grant_idx;
  logic            grant_vld;
  logic            grant_en;
  logic            out_free;
  logic            accept;
  logic            sel_last;
  logic [WIDTH-1:0] sel_data;

  // Output register can take a new beat when empty or draining this cycle
  assign out_free = !o_tvalid || o_tready;
  assign sel_last = i_tlast[active_port];
  assign sel_data = i_tdata[active_port*WIDTH +: WIDTH];

  // Round-robin search: first valid port at or after rr_ptr, wrapping
  always_comb begin : rr_search
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      if (!grant_vld && i_tvalid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, grant strobe and per-port ready
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    accept    = 1'b0;
    i_tready  = '0;
    case (state)
      IDLE: begin
        if (calib_complete && grant_vld) begin
          grant_en  = 1'b1;
          state_nxt = PASS;
        end
      end
      PASS: begin
        i_tready[active_port] = out_free;
        accept = out_free && i_tvalid[active_port];
        // Packet ends when its tlast beat is taken; calib only gates new grants
        if (accept && sel_last) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant bookkeeping: active port and next search start
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      active_port <= '0;
      rr_ptr      <= '0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_nxt == PASS);
      if (grant_en) begin
        active_port <= grant_idx;
        rr_ptr      <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
      end
    end
  end

  // Output pipeline register; holds while stalled by the FIFO
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
    end else if (accept) begin
      o_tvalid <= 1'b1;
      o_tdata  <= sel_data;
      o_tlast  <= sel_last;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  // Count packets as their last beat enters the FIFO
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      pkt_count <= 32'd0;
    end else if (o_tvalid && o_tready && o_tlast) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_axis_dram_fifo_arbiter.sv
// Scoreboard bench for axis_dram_fifo_arbiter: drivers push expected beats into a queue,
// a negedge monitor pops and compares every beat the FIFO side accepts.
module tb_axis_dram_fifo_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 calib;
  logic [N*W-1:0]       i_tdata;
  logic [N-1:0]         i_tlast;
  logic [N-1:0]         i_tvalid;
  logic [N-1:0]         i_tready;
  logic [W-1:0]         o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;
  logic [1:0]           active_port;
  logic                 busy;
  logic [31:0]          pkt_count;

  logic [W-1:0]         tdata_a [N];
  logic                 vld_a [N];
  logic                 last_a [N];

  int                   total = 0;
  int                   bad = 0;
  int                   cyc = 0;
  int                   beats_sent [N];
  bit                   abort = 1'b0;
  logic [64:0]          exp_q [$];
  logic [64:0]          exp_beat;
  logic [64:0]          prev;
  bit                   have_prev = 1'b0;
  int                   t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int p = 0; p < N; p++) begin
      i_tdata[p*W +: W] = tdata_a[p];
      i_tvalid[p]       = vld_a[p];
      i_tlast[p]        = last_a[p];
    end
  end

  axis_dram_fifo_arbiter #(.NUM_PORTS(N), .WIDTH(W)) dut (
    .bus_clk        (clk),
    .bus_rst_n      (rst_n),
    .calib_complete (calib),
    .i_tdata        (i_tdata),
    .i_tlast        (i_tlast),
    .i_tvalid       (i_tvalid),
    .i_tready       (i_tready),
    .o_tdata        (o_tdata),
    .o_tlast        (o_tlast),
    .o_tvalid       (o_tvalid),
    .o_tready       (o_tready),
    .active_port    (active_port),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  function automatic logic [63:0] mk(input int p, input int id, input int b);
    return {8'(p), 24'(id), 32'(b)};
  endfunction

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  function automatic void push_pkt(input int p, input int id, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({(b == n - 1), mk(p, id, b)});
  endfunction

  // Present one packet on port p, one beat per accepted handshake
  task automatic send_pkt(input int p, input int id, input int n);
    int t;
    for (int b = 0; b < n; b++) begin
      tdata_a[p] = mk(p, id, b);
      last_a[p]  = (b == n - 1);
      vld_a[p]   = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!i_tready[p] && !abort && t < 3000);
      if (abort) break;
      if (!i_tready[p]) begin
        check("send_timeout", 65'(0), 65'(1));
        break;
      end
      @(posedge clk);
      #1;
      beats_sent[p]++;
    end
    vld_a[p]  = 1'b0;
    last_a[p] = 1'b0;
  endtask

  task automatic wait_beats(input int p, input int n, input int lim);
    int t;
    t = 0;
    while (beats_sent[p] < n && t < lim) begin
      @(posedge clk);
      #2;
      t++;
    end
    check("wait_beats", 65'(beats_sent[p] >= n), 65'(1));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", 65'(exp_q.size()), 65'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    abort = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    abort = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every FIFO-side handshake must match the head of the queue
  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        check("hold_valid", 65'(o_tvalid), 65'(1));
        check("hold_beat", {o_tlast, o_tdata}, prev);
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 65'(1), 65'(0));
        end else begin
          exp_beat = exp_q.pop_front();
          check("beat", {o_tlast, o_tdata}, exp_beat);
        end
      end
      have_prev = o_tvalid && !o_tready;
      prev      = {o_tlast, o_tdata};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    calib    = 1'b0;
    o_tready = 1'b1;
    for (int p = 0; p < N; p++) begin
      tdata_a[p]    = '0;
      vld_a[p]      = 1'b0;
      last_a[p]     = 1'b0;
      beats_sent[p] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_tvalid", 65'(o_tvalid), 65'(0));
    check("rst_busy", 65'(busy), 65'(0));
    check("rst_pkt_count", 65'(pkt_count), 65'(0));
    check("rst_i_tready", 65'(i_tready), 65'(0));
    check("rst_active_port", 65'(active_port), 65'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: grant withheld until calibration completes
    push_pkt(0, 1, 10);
    fork
      send_pkt(0, 1, 10);
      begin
        repeat (5) @(posedge clk);
        #2;
        check("nocal_i_tready", 65'(i_tready), 65'(0));
        check("nocal_busy", 65'(busy), 65'(0));
        calib = 1'b1;
      end
    join
    drain();
    check("t1_pkt_count", 65'(pkt_count), 65'(1));

    // 2: four simultaneous ports from reset come out in order 0,1,2,3
    do_reset();
    push_pkt(0, 2, 100);
    push_pkt(1, 3, 100);
    push_pkt(2, 4, 100);
    push_pkt(3, 5, 100);
    fork
      send_pkt(0, 2, 100);
      send_pkt(1, 3, 100);
      send_pkt(2, 4, 100);
      send_pkt(3, 5, 100);
    join
    drain();
    check("t2_pkt_count", 65'(pkt_count), 65'(4));

    // 3: port2 alone, 20 back-to-back packets, one idle cycle between packets
    for (int k = 0; k < 20; k++) push_pkt(2, 100 + k, 100);
    t0 = cyc;
    for (int k = 0; k < 20; k++) send_pkt(2, 100 + k, 100);
    check("t3_cycles", 65'(cyc - t0), 65'(2020));
    check("t3_active_port", 65'(active_port), 65'(2));
    drain();
    check("t3_pkt_count", 65'(pkt_count), 65'(24));

    // 4: output stalled, first beat held, then 200 beats drain intact
    o_tready = 1'b0;
    push_pkt(1, 200, 200);
    fork
      send_pkt(1, 200, 200);
      begin
        repeat (20) @(posedge clk);
        #2;
        check("stall_o_tvalid", 65'(o_tvalid), 65'(1));
        check("stall_o_tdata", 65'(o_tdata), 65'(mk(1, 200, 0)));
        check("stall_i_tready", 65'(i_tready), 65'(0));
        check("stall_busy", 65'(busy), 65'(1));
        o_tready = 1'b1;
      end
    join
    drain();
    check("t4_pkt_count", 65'(pkt_count), 65'(25));

    // 5: calibration drops mid-packet; packet completes, pending port1 waits
    beats_sent[0] = 0;
    beats_sent[1] = 0;
    push_pkt(0, 300, 100);
    push_pkt(1, 301, 10);
    fork
      send_pkt(0, 300, 100);
      begin
        wait_beats(0, 50, 500);
        calib = 1'b0;
        send_pkt(1, 301, 10);
      end
      begin
        wait_beats(0, 100, 1000);
        repeat (20) @(posedge clk);
        #2;
        check("t5_hold_busy", 65'(busy), 65'(0));
        check("t5_hold_i_tready", 65'(i_tready), 65'(0));
        check("t5_mid_pkt_count", 65'(pkt_count), 65'(26));
        check("t5_beats_port1", 65'(beats_sent[1]), 65'(0));
        calib = 1'b1;
      end
    join
    drain();
    check("t5_pkt_count", 65'(pkt_count), 65'(27));

    // 6: asynchronous reset mid-packet clears outputs at once
    beats_sent[3] = 0;
    push_pkt(3, 400, 30);
    fork
      send_pkt(3, 400, 30);
      begin
        wait_beats(3, 10, 500);
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check("mrst_o_tvalid", 65'(o_tvalid), 65'(0));
        check("mrst_busy", 65'(busy), 65'(0));
        check("mrst_pkt_count", 65'(pkt_count), 65'(0));
        check("mrst_i_tready", 65'(i_tready), 65'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort = 1'b0;
      end
    join
    check("mrst_active_port", 65'(active_port), 65'(0));
    push_pkt(0, 500, 5);
    send_pkt(0, 500, 5);
    drain();
    check("t6_pkt_count", 65'(pkt_count), 65'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
